// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller. IDLE/REQ/DONE FSM with lane steering,
// load extension, timeout and flush. Optional LSU_MISALIGN_CHECK_EN adds misalign errors.
// Ports: clk, rst_n | memtoreg, memwrite, memsize, addr, wdata, flush -> stall, done,
//        rdata, err | mem_req, mem_we, mem_addr, mem_wmask, mem_wdata <- mem_ack, mem_rdata.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memtoreg,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        load_q, load_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        acc;
  logic        valid;
  logic        misalign;
  logic        bad;
  logic        kill;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] ld_data;

  assign acc = memtoreg | memwrite;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((memsize[1:0] == 2'b01) && addr[0]) ||
                    ((memsize == 3'b010) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign bad = !valid || misalign;

  // store lane steering and size validity for the presented access
  always_comb begin
    st_mask = 4'b1111;
    st_data = wdata;
    valid   = 1'b1;
    case (memsize)
      3'b000: begin
        st_mask = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      3'b001: begin
        st_mask = 4'b0011 << {addr[1], 1'b0};
        st_data = {2{wdata[15:0]}};
      end
      3'b010: ;
      3'b100, 3'b101: valid = !memwrite;
      default: valid = 1'b0;
    endcase
  end

  // load extraction from the latched size and byte offset
  always_comb begin
    byte_sh = mem_rdata >> {off_q, 3'b000};
    half_sh = mem_rdata >> {off_q[1], 4'b0000};
    ld_data = mem_rdata;
    case (size_q)
      3'b000: ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001: ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100: ld_data = {24'h0, byte_sh[7:0]};
      3'b101: ld_data = {16'h0, half_sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // a flush seen at any point of the handshake discards the result
  assign kill = kill_q | flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    load_d      = load_q;
    size_d      = size_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (acc && !flush) begin
          if (bad) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            cnt_d       = 8'd0;
            kill_d      = 1'b0;
            load_d      = !memwrite;
            size_d      = memsize;
            off_d       = addr[1:0];
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_we_d    = memwrite;
            mem_wmask_d = memwrite ? st_mask : 4'b0000;
            mem_wdata_d = memwrite ? st_data : 32'h0;
          end
        end
      end
      S_REQ: begin
        kill_d = kill;
        if (mem_ack) begin
          state_d = kill ? S_IDLE : S_DONE;
          if (!kill) begin
            err_d = 1'b0;
            if (load_q) rdata_d = ld_data;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = kill ? S_IDLE : S_DONE;
          if (!kill) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      kill_q      <= 1'b0;
      load_q      <= 1'b0;
      size_q      <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      load_q      <= load_d;
      size_q      <= size_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign rdata     = rdata_q;

  // stall masked by reset since pipeline inputs may be pending during reset
  assign stall = rst_n &&
                 (((state_q == S_IDLE) && acc && !flush) ||
                  (state_q == S_REQ));

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl (TIMEOUT=4).
// Inputs driven 1 unit after posedge, outputs checked 5 units after posedge.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memtoreg = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  memsize = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memtoreg  (memtoreg),
    .memwrite  (memwrite),
    .memsize   (memsize),
    .addr      (addr),
    .wdata     (wdata),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic st,
                         input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
    memtoreg = ld;
    memwrite = st;
    memsize  = sz;
    addr     = a;
    wdata    = d;
  endtask

  task automatic quiet();
    memtoreg = 1'b0;
    memwrite = 1'b0;
    flush    = 1'b0;
  endtask

  // cycle 0 present, cycle 1 ack with rd; returns mid cycle 1
  task automatic begin_acc(input logic ld, input logic st,
                           input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd);
    present(ld, st, sz, a, d);
    nxt();
    quiet();
    mem_ack   = 1'b1;
    mem_rdata = rd;
    #4;
  endtask

  // advances to mid cycle 2 with ack dropped
  task automatic end_acc();
    nxt();
    mem_ack = 1'b0;
    #4;
  endtask

  initial begin
    exp_rd = 32'h0;
    memtoreg = 1'b1;
    #3;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_mask", 32'(mem_wmask), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    nxt();
    memtoreg = 1'b0;
    rst_n = 1'b1;
    nxt();

    present(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    #4;
    chk("sw_stall0", 32'(stall), 32'h1);
    chk("sw_req0", 32'(mem_req), 32'h0);
    nxt();
    quiet();
    mem_ack = 1'b1;
    #4;
    chk("sw_req1", 32'(mem_req), 32'h1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_mask", 32'(mem_wmask), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(mem_we), 32'h1);
    end_acc();
    chk("sw_done", 32'(done), 32'h1);
    chk("sw_err", 32'(err), 32'h0);
    chk("sw_stall2", 32'(stall), 32'h0);
    chk("sw_req2", 32'(mem_req), 32'h0);
    nxt();
    #4;
    chk("sw_done3", 32'(done), 32'h0);
    nxt();

    begin_acc(1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0);
    chk("sb_mask", 32'(mem_wmask), 32'h2);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    end_acc();
    chk("sb_done", 32'(done), 32'h1);
    nxt();

    begin_acc(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_mask", 32'(mem_wmask), 32'h0);
    chk("lb_we", 32'(mem_we), 32'h0);
    end_acc();
    chk("lb_done", 32'(done), 32'h1);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    nxt();

    begin_acc(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF);
    end_acc();
    chk("lbu_rdata", rdata, 32'h00000080);
    nxt();

    begin_acc(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0);
    chk("sh_mask", 32'(mem_wmask), 32'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    end_acc();
    nxt();

    begin_acc(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'hBEEF1234);
    end_acc();
    exp_rd = 32'hFFFFBEEF;
    chk("lh_rdata", rdata, exp_rd);
    nxt();

    present(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    nxt();
    quiet();
    for (int i = 0; i < 4; i++) begin
      #4;
      chk("to_req", 32'(mem_req), 32'h1);
      chk("to_stall", 32'(stall), 32'h1);
      nxt();
    end
    #4;
    chk("to_drop", 32'(mem_req), 32'h0);
    chk("to_done", 32'(done), 32'h1);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rdata", rdata, exp_rd);
    nxt();

    present(1'b0, 1'b1, 3'b100, 32'h10, 32'h0);
    #4;
    chk("inv_stall", 32'(stall), 32'h1);
    nxt();
    quiet();
    #4;
    chk("inv_req", 32'(mem_req), 32'h0);
    chk("inv_done", 32'(done), 32'h1);
    chk("inv_err", 32'(err), 32'h1);
    nxt();
    #4;
    chk("inv_done2", 32'(done), 32'h0);
    nxt();

    present(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    flush = 1'b1;
    #4;
    chk("fi_stall", 32'(stall), 32'h0);
    nxt();
    quiet();
    #4;
    chk("fi_req", 32'(mem_req), 32'h0);
    chk("fi_done", 32'(done), 32'h0);
    nxt();

    begin_acc(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lwm_req", 32'(mem_req), 32'h0);
    chk("lwm_done", 32'(done), 32'h1);
    chk("lwm_err", 32'(err), 32'h1);
    end_acc();
`else
    chk("lwm_req", 32'(mem_req), 32'h1);
    chk("lwm_addr", mem_addr, 32'h100);
    end_acc();
    exp_rd = 32'hCAFEF00D;
    chk("lwm_done", 32'(done), 32'h1);
    chk("lwm_err", 32'(err), 32'h0);
    chk("lwm_rdata", rdata, exp_rd);
`endif
    nxt();

    present(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    nxt();
    quiet();
    #4;
    chk("fr_req1", 32'(mem_req), 32'h1);
    nxt();
    flush = 1'b1;
    #4;
    chk("fr_req2", 32'(mem_req), 32'h1);
    chk("fr_stall2", 32'(stall), 32'h1);
    nxt();
    flush = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    #4;
    chk("fr_req3", 32'(mem_req), 32'h1);
    nxt();
    mem_ack = 1'b0;
    #4;
    chk("fr_done", 32'(done), 32'h0);
    chk("fr_drop", 32'(mem_req), 32'h0);
    chk("fr_rdata", rdata, exp_rd);
    chk("fr_stall", 32'(stall), 32'h0);
    nxt();

    present(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
    nxt();
    quiet();
    flush = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h55AA55AA;
    #4;
    chk("fa_req", 32'(mem_req), 32'h1);
    nxt();
    flush = 1'b0;
    mem_ack = 1'b0;
    #4;
    chk("fa_done", 32'(done), 32'h0);
    chk("fa_drop", 32'(mem_req), 32'h0);
    chk("fa_rdata", rdata, exp_rd);
    nxt();

    present(1'b0, 1'b1, 3'b010, 32'h400, 32'h11111111);
    nxt();
    quiet();
    #4;
    chk("rr_req", 32'(mem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rr_drop", 32'(mem_req), 32'h0);
    chk("rr_stall", 32'(stall), 32'h0);
    chk("rr_addr", mem_addr, 32'h0);
    chk("rr_mask", 32'(mem_wmask), 32'h0);
    nxt();
    #4;
    chk("rr_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
